// File: rtl/uart_hex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_hex_pkg
// Description : Shared definitions for the ASCII-hex program loader: ASCII
//               constants, loader FSM state encoding and character classes.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_hex_pkg;

    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] SP    = 8'h20;
    localparam logic [7:0] AT    = 8'h40;
    localparam logic [7:0] QMARK = 8'h3F;
    localparam logic [7:0] BANG  = 8'h21;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_ECHO   = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        HEX    = 3'd0,
        EOL    = 3'd1,
        SEP    = 3'd2,
        CMD_AT = 3'd3,
        BAD    = 3'd4
    } char_class_e;

endpackage
`default_nettype wire

// File: rtl/hex_ascii_decode.sv
`default_nettype none
// ============================================================================
// Module      : hex_ascii_decode
// Description : Combinational byte classifier. Hex digits are accepted in
//               either case and returned with their nibble value.
// Ports       : ch  (in, 8)  byte to classify
//               cls (out)    character class
//               nib (out, 4) nibble value, valid when cls == HEX
// Revision    : 1.0 - initial release
// ============================================================================
module hex_ascii_decode
    import uart_hex_pkg::*;
(
    input  logic [7:0]  ch,
    output char_class_e cls,
    output logic [3:0]  nib
);

    always_comb begin
        cls = BAD;
        nib = 4'd0;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            cls = HEX;
            nib = ch[3:0];
        end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so adding 9 yields 10..15
            cls = HEX;
            nib = ch[3:0] + 4'd9;
        end else if (ch == CR || ch == LF) begin
            cls = EOL;
        end else if (ch == SP) begin
            cls = SEP;
        end else if (ch == AT) begin
            cls = CMD_AT;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_hex_loader.sv
`default_nettype none
// ============================================================================
// Module      : uart_hex_loader
// Description : Assembles ASCII hex digits from a UART byte stream into
//               WORD_W-bit words (MSB first), writes them to memory at an
//               auto-incrementing address and echoes each consumed byte.
// Ports       : clk, rst            clock, async active-high reset
//               rx_data/rx_valid    received byte / byte available
//               rx_ack              one-cycle consume pulse
//               tx_data/tx_wr       echo byte / transmit strobe
//               tx_busy             transmitter busy
//               mem_we/addr/wdata   memory write port
//               word_count          words written since '@' or reset
//               last_word           most recently committed word
//               err, full           sticky status flags
// Revision    : 1.0 - initial release
// ============================================================================
module uart_hex_loader
    import uart_hex_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int ECHO   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ack,
    output logic [7:0]        tx_data,
    output logic              tx_wr,
    input  logic              tx_busy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic [WORD_W-1:0] last_word,
    output logic              err,
    output logic              full
);

    localparam int NIB_W = $clog2(WORD_W / 4 + 1);
    localparam logic [NIB_W-1:0]  c_NIB_LAST  = NIB_W'(WORD_W / 4 - 1);
    localparam logic [ADDR_W-1:0] c_ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   c_CNT_MAX   = (ADDR_W + 1)'(DEPTH);

    state_e              r_state, w_state_nxt;
    logic [7:0]          r_byte;
    logic [7:0]          r_echo;
    logic [WORD_W-1:0]   r_acc;
    logic [NIB_W-1:0]    r_nib_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_rx_ack, r_tx_wr, r_mem_we, r_err, r_full;
    logic [7:0]          r_tx_data;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [WORD_W-1:0]   r_mem_wdata, r_last_word;
    logic [ADDR_W:0]     r_word_count;

    char_class_e         w_cls;
    logic [3:0]          w_nib;
    logic [WORD_W-1:0]   w_acc_shift;
    logic [WORD_W-1:0]   w_word;
    logic                w_commit;
    logic [7:0]          w_echo;

    hex_ascii_decode u_decode (
        .ch  (r_byte),
        .cls (w_cls),
        .nib (w_nib)
    );

    assign w_acc_shift = {r_acc[WORD_W-5:0], w_nib};

    // Decision for the latched byte: whether it completes a word, the word
    // value, and which byte goes back to the host.
    always_comb begin
        w_commit = 1'b0;
        w_word   = r_acc;
        w_echo   = r_byte;
        case (w_cls)
            HEX: begin
                if (r_full) begin
                    w_echo = BANG;
                end else if (r_nib_cnt == c_NIB_LAST) begin
                    w_commit = 1'b1;
                    w_word   = w_acc_shift;
                end
            end
            EOL:     w_commit = (r_nib_cnt != '0) && !r_full;
            BAD:     w_echo   = QMARK;
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (rx_valid) w_state_nxt = S_DECODE;
            S_DECODE: w_state_nxt = (ECHO != 0) ? S_ECHO : S_IDLE;
            S_ECHO:   if (!tx_busy) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte       <= '0;
            r_echo       <= '0;
            r_acc        <= '0;
            r_nib_cnt    <= '0;
            r_addr       <= '0;
            r_rx_ack     <= 1'b0;
            r_tx_wr      <= 1'b0;
            r_tx_data    <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_last_word  <= '0;
            r_word_count <= '0;
            r_err        <= 1'b0;
            r_full       <= 1'b0;
        end else begin
            r_rx_ack <= 1'b0;
            r_tx_wr  <= 1'b0;
            r_mem_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (rx_valid) begin
                        r_byte   <= rx_data;
                        r_rx_ack <= 1'b1;
                    end
                end
                S_DECODE: begin
                    r_echo <= w_echo;
                    case (w_cls)
                        HEX: begin
                            if (!r_full) begin
                                r_acc     <= w_acc_shift;
                                r_nib_cnt <= r_nib_cnt + NIB_W'(1);
                            end
                        end
                        CMD_AT: begin
                            r_addr       <= '0;
                            r_nib_cnt    <= '0;
                            r_acc        <= '0;
                            r_word_count <= '0;
                            r_full       <= 1'b0;
                            r_err        <= 1'b0;
                        end
                        BAD: begin
                            r_err     <= 1'b1;
                            r_nib_cnt <= '0;
                            r_acc     <= '0;
                        end
                        default: ;
                    endcase
                    // Placed after the class actions so a completing digit
                    // leaves the accumulator and nibble count cleared.
                    if (w_commit) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= w_word;
                        r_last_word <= w_word;
                        r_nib_cnt   <= '0;
                        r_acc       <= '0;
                        if (r_word_count != c_CNT_MAX)
                            r_word_count <= r_word_count + (ADDR_W + 1)'(1);
                        if (r_addr == c_ADDR_LAST) begin
                            r_full <= 1'b1;
                            r_addr <= '0;
                        end else begin
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                    end
                end
                S_ECHO: begin
                    if (!tx_busy) begin
                        r_tx_data <= r_echo;
                        r_tx_wr   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rx_ack     = r_rx_ack;
    assign tx_data    = r_tx_data;
    assign tx_wr      = r_tx_wr;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign word_count = r_word_count;
    assign last_word  = r_last_word;
    assign err        = r_err;
    assign full       = r_full;

endmodule
`default_nettype wire

// File: tb/tb_uart_hex_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_hex_loader
// Description : Self-checking bench for uart_hex_loader (WORD_W=32, DEPTH=4,
//               ECHO=1): table of byte strings with expected results,
//               hand-written busy/reset sequences, and random bytes checked
//               against a behavioural loader model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_hex_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ack;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_busy;
    logic        mem_we;
    logic [1:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  word_count;
    logic [31:0] last_word;
    logic        err;
    logic        full;

    uart_hex_loader #(.WORD_W(32), .DEPTH(4), .ECHO(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ack     (rx_ack),
        .tx_data    (tx_data),
        .tx_wr      (tx_wr),
        .tx_busy    (tx_busy),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .word_count (word_count),
        .last_word  (last_word),
        .err        (err),
        .full       (full)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural loader model ----------------
    longint      m_acc;
    int          m_nd, m_addr, m_wc;
    bit          m_err, m_full;
    logic [31:0] m_last;

    task automatic model_reset();
        m_acc = 0; m_nd = 0; m_addr = 0; m_wc = 0;
        m_err = 0; m_full = 0; m_last = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, output logic [7:0] e,
                              output bit we, output int a, output logic [31:0] d);
        int v;
        bit commit;
        v = -1; commit = 0;
        e = b; we = 0; a = 0; d = 0;
        if (b >= 8'h30 && b <= 8'h39)      v = int'(b) - 48;
        else if (b >= 8'h41 && b <= 8'h46) v = int'(b) - 65 + 10;
        else if (b >= 8'h61 && b <= 8'h66) v = int'(b) - 97 + 10;
        if (v >= 0) begin
            if (m_full) e = 8'h21;
            else begin
                m_acc = (m_acc * 16 + v) % 64'h1_0000_0000;
                m_nd++;
                commit = (m_nd == 8);
            end
        end else if (b == 8'h0D || b == 8'h0A) begin
            commit = (m_nd > 0) && !m_full;
        end else if (b == 8'h20) begin
        end else if (b == 8'h40) begin
            m_acc = 0; m_nd = 0; m_addr = 0; m_wc = 0; m_err = 0; m_full = 0;
        end else begin
            m_err = 1; m_nd = 0; m_acc = 0; e = 8'h3F;
        end
        if (commit) begin
            we = 1; a = m_addr; d = m_acc[31:0];
            m_last = d;
            if (m_wc < 4) m_wc++;
            m_nd = 0; m_acc = 0;
            if (m_addr == 3) begin m_full = 1; m_addr = 0; end
            else m_addr++;
        end
    endtask

    // ---------------- one complete byte transaction ----------------
    task automatic send_byte(input logic [7:0] b, input bit rbusy,
                             output logic [7:0] echo, output int nwr,
                             output logic [1:0] waddr, output logic [31:0] wdata,
                             output bit ok);
        bit got_ack, got_tx;
        echo = 0; nwr = 0; waddr = 0; wdata = 0;
        @(negedge clk);
        rx_data = b; rx_valid = 1'b1;
        got_ack = 0;
        for (int c = 0; c < 200 && !got_ack; c++) begin
            @(posedge clk); #1;
            if (rx_ack) begin got_ack = 1; rx_valid = 1'b0; end
        end
        got_tx = 0;
        for (int c = 0; c < 200 && got_ack && !got_tx; c++) begin
            if (rbusy) tx_busy = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
            if (mem_we) begin nwr++; waddr = mem_addr; wdata = mem_wdata; end
            if (tx_wr) begin got_tx = 1; echo = tx_data; end
        end
        tx_busy = 1'b0;
        rx_valid = 1'b0;
        ok = got_ack && got_tx;
    endtask

    typedef struct {
        string       s;
        string       echo;
        int          nwr;
        logic [1:0]  addr;
        logic [31:0] data;
        bit          err;
        bit          full;
        int          wc;
        logic [31:0] last;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [7:0]  e, me;
        int          nwr, ma;
        logic [1:0]  wa;
        logic [31:0] wd, md, lwd;
        logic [1:0]  lwa;
        bit          ok, mwe;
        int          acks, txw, tot;
        string       s;

        tbl[0] = '{"DEADBEEF", "DEADBEEF", 1, 2'd0, 32'hDEADBEEF, 0, 0, 1, 32'hDEADBEEF};
        tbl[1] = '{"12ab\r",   "12ab\r",   1, 2'd1, 32'h000012AB, 0, 0, 2, 32'h000012AB};
        tbl[2] = '{"12G",      "12?",      0, 2'd0, 32'h0,        1, 0, 2, 32'h000012AB};
        tbl[3] = '{"00000001", "00000001", 1, 2'd2, 32'h00000001, 1, 0, 3, 32'h00000001};
        tbl[4] = '{"11111111", "11111111", 1, 2'd3, 32'h11111111, 1, 1, 4, 32'h11111111};
        tbl[5] = '{"5",        "!",        0, 2'd0, 32'h0,        1, 1, 4, 32'h11111111};
        tbl[6] = '{"\r",       "\r",       0, 2'd0, 32'h0,        1, 1, 4, 32'h11111111};
        tbl[7] = '{"@",        "@",        0, 2'd0, 32'h0,        0, 0, 0, 32'h11111111};
        tbl[8] = '{"7 \n",     "7 \n",     1, 2'd0, 32'h00000007, 0, 0, 1, 32'h00000007};

        rst = 1'b1; rx_data = 0; rx_valid = 0; tx_busy = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctl", {rx_ack, tx_data, tx_wr, mem_we, mem_addr, word_count, err, full}, 0);
        chk("reset_wdata", mem_wdata, 0);
        chk("reset_last", last_word, 0);
        @(negedge clk); rst = 1'b0;

        // ---------------- table-driven strings ----------------
        for (int i = 0; i < 9; i++) begin
            tot = 0; lwa = 0; lwd = 0;
            s = tbl[i].s;
            for (int j = 0; j < s.len(); j++) begin
                send_byte(s[j], 1'b0, e, nwr, wa, wd, ok);
                model_byte(s[j], me, mwe, ma, md);
                chk($sformatf("tbl%0d_hs", i), ok, 1);
                chk($sformatf("tbl%0d_echo%0d", i, j), e, tbl[i].echo[j]);
                tot += nwr;
                if (nwr > 0) begin lwa = wa; lwd = wd; end
            end
            chk($sformatf("tbl%0d_nwr", i), tot, tbl[i].nwr);
            if (tbl[i].nwr > 0) begin
                chk($sformatf("tbl%0d_addr", i), lwa, tbl[i].addr);
                chk($sformatf("tbl%0d_data", i), lwd, tbl[i].data);
            end
            chk($sformatf("tbl%0d_err", i), err, tbl[i].err);
            chk($sformatf("tbl%0d_full", i), full, tbl[i].full);
            chk($sformatf("tbl%0d_wc", i), word_count, tbl[i].wc);
            chk($sformatf("tbl%0d_last", i), last_word, tbl[i].last);
        end

        // ---------------- echo stalled by tx_busy ----------------
        @(negedge clk);
        tx_busy = 1'b1; rx_data = 8'h33; rx_valid = 1'b1;
        acks = 0; txw = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (rx_ack) begin acks++; rx_valid = 1'b0; end
            else if (acks > 0) begin rx_data = 8'h34; rx_valid = 1'b1; end
            if (tx_wr) txw++;
        end
        model_byte(8'h33, me, mwe, ma, md);
        chk("busy_acks", acks, 1);
        chk("busy_txwr", txw, 0);
        @(negedge clk); tx_busy = 1'b0;
        @(posedge clk); #1;
        chk("busy_release_txwr", tx_wr, 1);
        chk("busy_release_data", tx_data, 8'h33);
        chk("busy_release_noack", rx_ack, 0);
        ok = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(posedge clk); #1;
            if (rx_ack) begin ok = 1; rx_valid = 1'b0; end
        end
        chk("busy_second_ack", ok, 1);
        ok = 0; e = 0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(posedge clk); #1;
            if (tx_wr) begin ok = 1; e = tx_data; end
        end
        model_byte(8'h34, me, mwe, ma, md);
        chk("busy_second_echo", e, 8'h34);

        // ---------------- random bytes vs model ----------------
        for (int k = 0; k < 200; k++) begin
            logic [7:0] b;
            int r;
            string hexs;
            hexs = "0123456789abcdefABCDEF";
            r = $urandom_range(0, 99);
            if (r < 70)      b = hexs[$urandom_range(0, 21)];
            else if (r < 80) b = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
            else if (r < 88) b = 8'h20;
            else if (r < 92) b = 8'h40;
            else             b = 8'($urandom_range(0, 255));
            send_byte(b, 1'b1, e, nwr, wa, wd, ok);
            model_byte(b, me, mwe, ma, md);
            chk("rnd_hs", ok, 1);
            chk("rnd_echo", e, me);
            chk("rnd_nwr", nwr, mwe ? 1 : 0);
            if (mwe) begin
                chk("rnd_addr", wa, ma[1:0]);
                chk("rnd_data", wd, md);
            end
            chk("rnd_err", err, m_err);
            chk("rnd_full", full, m_full);
            chk("rnd_wc", word_count, m_wc);
            chk("rnd_last", last_word, m_last);
        end

        // ---------------- reset in the middle of a word ----------------
        s = "ABC";
        for (int j = 0; j < 3; j++) begin
            send_byte(s[j], 1'b0, e, nwr, wa, wd, ok);
            chk("abc_hs", ok, 1);
        end
        @(negedge clk); rx_data = 8'h44; rx_valid = 1'b1;
        @(posedge clk); #1;
        chk("midrst_ack_seen", rx_ack, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_ctl", {rx_ack, tx_data, tx_wr, mem_we, mem_addr, word_count, err, full}, 0);
        chk("midrst_wdata", mem_wdata, 0);
        chk("midrst_last", last_word, 0);
        @(negedge clk); rx_valid = 1'b0; rst = 1'b0;
        model_reset();
        s = "00000005";
        tot = 0; lwa = 2'd3; lwd = 0;
        for (int j = 0; j < 8; j++) begin
            send_byte(s[j], 1'b0, e, nwr, wa, wd, ok);
            chk("post_rst_echo", e, s[j]);
            tot += nwr;
            if (nwr > 0) begin lwa = wa; lwd = wd; end
        end
        chk("post_rst_nwr", tot, 1);
        chk("post_rst_addr", lwa, 0);
        chk("post_rst_data", lwd, 32'h00000005);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
